// File: rtl/jk_ff_if.sv
// jk_ff_if: per-bit J/K inputs and complementary state outputs of a jk_ff.
// master drives j/k and observes q/qb; slave is the flip-flop side.
interface jk_ff_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    modport master (output j, output k, input q, input qb);
    modport slave (input j, input k, output q, output qb);
endinterface

// File: rtl/jk_ff.sv
// jk_ff: vector of independent edge-triggered JK flip-flops with complementary outputs.
// Asynchronous active-low reset loads RESET_VAL; qb is derived from q, never stored.
module jk_ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic    clk,
    input  logic    rst,
    jk_ff_if.slave  bus
);
    logic [WIDTH-1:0] r_q;
    // set where j and q=0, keep where k is low and q=1: covers hold/set/reset/toggle per bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_q <= RESET_VAL;
        else      r_q <= (bus.j & ~r_q) | (~bus.k & r_q);
    end
    assign bus.q  = r_q;
    assign bus.qb = ~r_q;
endmodule

// File: tb/tb_jk_ff.sv
// tb_jk_ff: directed and randomized checks of 1-bit and 4-bit jk_ff against a truth-table model.
module tb_jk_ff;
    localparam logic [3:0] RV4 = 4'b0110;
    logic clk = 1'b0;
    logic rst;
    logic chk_on = 1'b0;
    logic e1;
    logic [3:0] e4;
    bit tt [4][2];
    int n_chk = 0;
    int n_pass = 0;
    jk_ff_if #(.WIDTH(1)) b1 ();
    jk_ff_if #(.WIDTH(4)) b4 ();
    jk_ff #(.WIDTH(1), .RESET_VAL(1'b0)) u1 (.clk(clk), .rst(rst), .bus(b1));
    jk_ff #(.WIDTH(4), .RESET_VAL(RV4))  u4 (.clk(clk), .rst(rst), .bus(b4));
    always #5 clk = ~clk;
    task automatic chk(input string n, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", n, act, exp, $time);
    endtask
    // next state looked up per bit from the characteristic table tt[{j,k}][q]
    function automatic logic [3:0] nxt(input logic [3:0] q, input logic [3:0] j, input logic [3:0] k);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = tt[{j[i], k[i]}][q[i]];
        return r;
    endfunction
    task automatic tick(input logic a1, input logic c1, input logic [3:0] a4, input logic [3:0] c4);
        logic [3:0] t;
        logic r_at;
        b1.j = a1; b1.k = c1; b4.j = a4; b4.k = c4;
        @(posedge clk);
        r_at = rst;
        #1;
        if (r_at) begin
            t  = nxt({3'b0, e1}, {3'b0, a1}, {3'b0, c1});
            e1 = t[0];
            e4 = nxt(e4, a4, c4);
        end
    endtask
    task automatic tick_r1(input logic a1, input logic c1);
        tick(a1, c1, 4'($urandom), 4'($urandom));
    endtask
    task automatic async_rst();
        #2;
        rst = 1'b0;
        e1  = 1'b0;
        e4  = RV4;
    endtask
    always @(negedge clk) begin
        if (chk_on) begin
            chk("q1", {3'b0, b1.q}, {3'b0, e1});
            chk("qb1", {3'b0, b1.qb}, {3'b0, ~e1});
            chk("q4", b4.q, e4);
            chk("qb4", b4.qb, ~e4);
        end
    end
    initial begin
        bit seq [5];
        tt[0] = '{1'b0, 1'b1};
        tt[1] = '{1'b0, 1'b0};
        tt[2] = '{1'b1, 1'b1};
        tt[3] = '{1'b1, 1'b0};
        seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        rst = 1'b1;
        b1.j = 1'b1; b1.k = 1'b0; b4.j = 4'hf; b4.k = 4'h0;
        e1 = 1'b0;
        e4 = RV4;
        #1 rst = 1'b0;
        #1;
        chk("rst_q1", {3'b0, b1.q}, 4'b0000);
        chk("rst_qb1", {3'b0, b1.qb}, 4'b0001);
        chk("rst_q4", b4.q, 4'b0110);
        chk_on = 1'b1;
        tick(1'b1, 1'b0, 4'hf, 4'h0);
        tick(1'b1, 1'b0, 4'hf, 4'h0);
        chk("rst_ignore_q1", {3'b0, b1.q}, 4'b0000);
        chk("rst_ignore_q4", b4.q, 4'b0110);
        rst = 1'b1;
        tick_r1(1'b1, 1'b0);
        chk("tt_set", {3'b0, b1.q}, 4'b0001);
        tick_r1(1'b0, 1'b0);
        chk("tt_hold1", {3'b0, b1.q}, 4'b0001);
        tick_r1(1'b0, 1'b1);
        chk("tt_reset", {3'b0, b1.q}, 4'b0000);
        tick_r1(1'b0, 1'b0);
        chk("tt_hold0", {3'b0, b1.q}, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            tick_r1(1'b1, 1'b1);
            chk("toggle", {3'b0, b1.q}, {3'b0, seq[i]});
        end
        for (int i = 0; i < 3; i++) begin
            tick_r1(1'b0, 1'b0);
            chk("toggle_hold", {3'b0, b1.q}, 4'b0001);
        end
        b1.j = 1'b1; b1.k = 1'b1;
        async_rst();
        #1;
        chk("async_q1", {3'b0, b1.q}, 4'b0000);
        chk("async_qb1", {3'b0, b1.qb}, 4'b0001);
        chk("async_q4", b4.q, RV4);
        tick_r1(1'b1, 1'b1);
        rst = 1'b1;
        tick_r1(1'b1, 1'b1);
        chk("after_release", {3'b0, b1.q}, 4'b0001);
        async_rst();
        b1.j = 1'b1; b1.k = 1'b0; b4.j = 4'hf; b4.k = 4'h0;
        @(posedge clk);
        rst <= 1'b1;
        #1;
        chk("coincident_q1", {3'b0, b1.q}, 4'b0000);
        chk("coincident_q4", b4.q, RV4);
        tick(1'b1, 1'b0, 4'hf, 4'h0);
        chk("post_coincident_q1", {3'b0, b1.q}, 4'b0001);
        chk("post_coincident_q4", b4.q, 4'b1111);
        tick(1'b0, 1'b0, 4'h0, 4'hf);
        chk("vec_clear", b4.q, 4'b0000);
        tick(1'b0, 1'b0, 4'b1010, 4'b0110);
        chk("vec_edge1", b4.q, 4'b1010);
        chk("vec_edge1_qb", b4.qb, 4'b0101);
        tick(1'b0, 1'b0, 4'b1010, 4'b0110);
        chk("vec_edge2", b4.q, 4'b1000);
        chk("vec_edge2_qb", b4.qb, 4'b0111);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                async_rst();
                tick(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
                rst = 1'b1;
            end else begin
                tick(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
            end
        end
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
